// File: rtl/instr_enc_pkg.sv
// Shared types, constants and the ARMv4 word encoder for instr_encoder_loader.
package instr_enc_pkg;

  // Request class as presented on the req_op port
  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  // Loader session FSM
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFlush = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam logic [3:0] COND_AL = 4'hE;

  // Data-processing opcodes
  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_ORR = 4'b1100;

  // Instruction class tags in bits [27:26] / [27:25]
  localparam logic [1:0] CLASS_DP  = 2'b00;
  localparam logic [1:0] CLASS_MEM = 2'b01;
  localparam logic [2:0] CLASS_BR  = 3'b101;

  // Field bit positions
  localparam int unsigned BIT_COND_LSB  = 28;
  localparam int unsigned BIT_CLASS_LSB = 26;
  localparam int unsigned BIT_BRCLS_LSB = 25;
  localparam int unsigned BIT_I         = 25;
  localparam int unsigned BIT_CMD_LSB   = 21;
  localparam int unsigned BIT_P         = 24;
  localparam int unsigned BIT_U         = 23;
  localparam int unsigned BIT_B         = 22;
  localparam int unsigned BIT_W         = 21;
  localparam int unsigned BIT_S         = 20;
  localparam int unsigned BIT_L         = 20;
  localparam int unsigned BIT_LINK      = 24;
  localparam int unsigned BIT_RN_LSB    = 16;
  localparam int unsigned BIT_RD_LSB    = 12;

  // One structured request as seen on the request port
  typedef struct packed {
    op_e         op;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic        i;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [4:0]  shamt;
    logic [1:0]  sh;
    logic [11:0] imm12;
    logic [23:0] imm24;
    logic        l;
    logic        u;
  } enc_req_t;

  // Build the 32-bit word; illegal ops yield only the condition field (never pushed)
  function automatic logic [31:0] encode_word(input enc_req_t r, input logic bl_en);
    logic [31:0] w;
    w = '0;
    w[BIT_COND_LSB +: 4] = r.cond;
    case (r.op)
      OP_DP: begin
        w[BIT_CLASS_LSB +: 2] = CLASS_DP;
        w[BIT_I]              = r.i;
        w[BIT_CMD_LSB +: 4]   = r.cmd;
        w[BIT_S]              = r.s;
        w[BIT_RN_LSB +: 4]    = r.rn;
        w[BIT_RD_LSB +: 4]    = r.rd;
        w[11:0]               = r.i ? r.imm12 : {r.shamt, r.sh, 1'b0, r.rm};
      end
      OP_MEM: begin
        // Pre-indexed, word access, no write-back
        w[BIT_CLASS_LSB +: 2] = CLASS_MEM;
        w[BIT_I]              = 1'b0;
        w[BIT_P]              = 1'b1;
        w[BIT_U]              = r.u;
        w[BIT_B]              = 1'b0;
        w[BIT_W]              = 1'b0;
        w[BIT_L]              = r.l;
        w[BIT_RN_LSB +: 4]    = r.rn;
        w[BIT_RD_LSB +: 4]    = r.rd;
        w[11:0]               = r.imm12;
      end
      OP_BR: begin
        w[BIT_BRCLS_LSB +: 3] = CLASS_BR;
        w[BIT_LINK]           = r.l & bl_en;
        w[23:0]               = r.imm24;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with full/empty flags; DEPTH must be a power of two (>= 2).
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty
  logic [PtrW:0]      r_wptr;
  logic [PtrW:0]      r_rptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  // Flags and guarded handshakes; a push while full is refused even alongside a pop
  always_comb begin
    o_empty   = (r_wptr == r_rptr);
    o_full    = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
    w_do_push = i_push && !o_full;
    w_do_pop  = i_pop && !o_empty;
    o_data    = r_mem[r_rptr[PtrW-1:0]];
  end

  // Pointer update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate every read
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[PtrW-1:0]] <= i_data;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests into ARMv4 words, buffers them and writes them to
// instruction memory at consecutive addresses. Optional BL support: INSTR_ENC_BL_EN.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [3:0]        i_req_cond,
  input  logic [3:0]        i_req_cmd,
  input  logic              i_req_s,
  input  logic              i_req_i,
  input  logic [3:0]        i_req_rn,
  input  logic [3:0]        i_req_rd,
  input  logic [3:0]        i_req_rm,
  input  logic [4:0]        i_req_shamt,
  input  logic [1:0]        i_req_sh,
  input  logic [11:0]       i_req_imm12,
  input  logic [23:0]       i_req_imm24,
  input  logic              i_req_l,
  input  logic              i_req_u,
  input  logic              i_req_last,
  output logic              o_imem_we,
  input  logic              i_imem_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

`ifdef INSTR_ENC_BL_EN
  localparam logic BlEn = 1'b1;
`else
  localparam logic BlEn = 1'b0;
`endif

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  enc_req_t          w_req;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [31:0]       w_fifo_data;

  // Gather the request fields and encode the word combinationally
  always_comb begin
    w_req.op    = op_e'(i_req_op);
    w_req.cond  = i_req_cond;
    w_req.cmd   = i_req_cmd;
    w_req.s     = i_req_s;
    w_req.i     = i_req_i;
    w_req.rn    = i_req_rn;
    w_req.rd    = i_req_rd;
    w_req.rm    = i_req_rm;
    w_req.shamt = i_req_shamt;
    w_req.sh    = i_req_sh;
    w_req.imm12 = i_req_imm12;
    w_req.imm24 = i_req_imm24;
    w_req.l     = i_req_l;
    w_req.u     = i_req_u;
    w_word      = encode_word(w_req, BlEn);
  end

  // Handshake decode: illegal requests are accepted but never pushed
  always_comb begin
    o_req_ready = (r_state == StRun) && !w_fifo_full;
    w_accept    = i_req_valid && o_req_ready;
    w_illegal   = (w_req.op == OP_ILL) || ((w_req.op == OP_BR) && w_req.l && !BlEn);
    w_push      = w_accept && !w_illegal;
    w_pop       = o_imem_we && i_imem_ready;
  end

  // Write-port and status outputs; wdata is held at zero while nothing is queued
  always_comb begin
    o_imem_we    = !w_fifo_empty;
    o_imem_addr  = r_addr;
    o_imem_wdata = o_imem_we ? w_fifo_data : 32'h0;
    o_busy       = (r_state != StIdle);
    o_done       = (r_state == StDone);
    o_err        = r_err;
  end

  // Next-state logic for the load session
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_accept && i_req_last) w_state_next = StFlush;
      StFlush: if (w_fifo_empty) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Address counter: loads on session start, advances per completed write, wraps silently
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_addr <= i_base_addr;
    end else if (w_pop) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Sticky illegal-request flag, cleared when a new session starts
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if ((r_state == StIdle) && i_start) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (ADDR_W=6 and ADDR_W=4 instances).
module tb_instr_encoder_loader;
  import instr_enc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, req_valid, imem_ready;
  logic [5:0]  base_addr;
  logic [1:0]  req_op, req_sh;
  logic [3:0]  req_cond, req_cmd, req_rn, req_rd, req_rm;
  logic        req_s, req_i, req_l, req_u, req_last;
  logic [4:0]  req_shamt;
  logic [11:0] req_imm12;
  logic [23:0] req_imm24;

  logic        req_ready, imem_we, busy, done, err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        req_ready4, imem_we4, busy4, done4, err4;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_wdata4;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [37:0] log6[$];
  logic [35:0] log4[$];

  instr_encoder_loader #(.ADDR_W(6), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_cond(req_cond), .i_req_cmd(req_cmd), .i_req_s(req_s), .i_req_i(req_i),
    .i_req_rn(req_rn), .i_req_rd(req_rd), .i_req_rm(req_rm), .i_req_shamt(req_shamt),
    .i_req_sh(req_sh), .i_req_imm12(req_imm12), .i_req_imm24(req_imm24),
    .i_req_l(req_l), .i_req_u(req_u), .i_req_last(req_last), .o_imem_we(imem_we),
    .i_imem_ready(imem_ready), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  instr_encoder_loader #(.ADDR_W(4), .FIFO_DEPTH(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr[3:0]),
    .i_req_valid(req_valid), .o_req_ready(req_ready4), .i_req_op(req_op),
    .i_req_cond(req_cond), .i_req_cmd(req_cmd), .i_req_s(req_s), .i_req_i(req_i),
    .i_req_rn(req_rn), .i_req_rd(req_rd), .i_req_rm(req_rm), .i_req_shamt(req_shamt),
    .i_req_sh(req_sh), .i_req_imm12(req_imm12), .i_req_imm24(req_imm24),
    .i_req_l(req_l), .i_req_u(req_u), .i_req_last(req_last), .o_imem_we(imem_we4),
    .i_imem_ready(imem_ready), .o_imem_addr(imem_addr4), .o_imem_wdata(imem_wdata4),
    .o_busy(busy4), .o_done(done4), .o_err(err4)
  );

  // Record every completed write and every done cycle
  always @(posedge clk) begin
    if (!reset) begin
      if (imem_we && imem_ready)  log6.push_back({imem_addr, imem_wdata});
      if (imem_we4 && imem_ready) log4.push_back({imem_addr4, imem_wdata4});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    req_op = 2'b00; req_cond = 4'h0; req_cmd = 4'h0; req_s = 1'b0; req_i = 1'b0;
    req_rn = 4'h0; req_rd = 4'h0; req_rm = 4'h0; req_shamt = 5'h0; req_sh = 2'b00;
    req_imm12 = 12'h0; req_imm24 = 24'h0; req_l = 1'b0; req_u = 1'b0;
  endtask

  task automatic set_dp(input logic [3:0] cond, input logic [3:0] cmd, input logic s,
                        input logic i, input logic [3:0] rn, input logic [3:0] rd,
                        input logic [3:0] rm, input logic [4:0] shamt, input logic [1:0] sh,
                        input logic [11:0] imm12);
    clr_req();
    req_op = OP_DP; req_cond = cond; req_cmd = cmd; req_s = s; req_i = i; req_rn = rn;
    req_rd = rd; req_rm = rm; req_shamt = shamt; req_sh = sh; req_imm12 = imm12;
  endtask

  task automatic set_mem(input logic [3:0] cond, input logic l, input logic u,
                         input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] imm12);
    clr_req();
    req_op = OP_MEM; req_cond = cond; req_l = l; req_u = u; req_rn = rn; req_rd = rd;
    req_imm12 = imm12;
  endtask

  task automatic set_br(input logic [3:0] cond, input logic l, input logic [23:0] imm24);
    clr_req();
    req_op = OP_BR; req_cond = cond; req_l = l; req_imm24 = imm24;
  endtask

  // All tasks below are entered and left 1 time unit after a rising edge
  task automatic start_session(input logic [5:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic last);
    int n;
    n = 0;
    req_valid = 1'b1; req_last = last;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req accepted", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    int c0;
    n = 0;
    c0 = done_cnt;
    @(negedge clk);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, {31'h0, done}, 32'h1);
    @(negedge clk);
    chk({tag, " one done pulse"}, done_cnt - c0, 32'h1);
    chk({tag, " done dropped"}, {31'h0, done}, 32'h0);
    chk({tag, " idle"}, {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic chk_log6(input int idx, input logic [5:0] a, input logic [31:0] d);
    logic [37:0] e;
    e = (idx < log6.size()) ? log6[idx] : 38'bx;
    chk($sformatf("wr%0d addr", idx), {26'h0, e[37:32]}, {26'h0, a});
    chk($sformatf("wr%0d data", idx), e[31:0], d);
  endtask

  task automatic chk_log4(input int idx, input logic [3:0] a, input logic [31:0] d);
    logic [35:0] e;
    e = (idx < log4.size()) ? log4[idx] : 36'bx;
    chk($sformatf("w4r%0d addr", idx), {28'h0, e[35:32]}, {28'h0, a});
    chk($sformatf("w4r%0d data", idx), e[31:0], d);
  endtask

  logic [31:0] exp_b [8];
  int          c_before;

  initial begin
    exp_b = '{32'hE0543105, 32'hE0443FC5, 32'hE5910008, 32'hE5010004,
              32'hE0010002, 32'hE38760FF, 32'hE3520001, 32'h0AFFFFFE};
    reset = 1'b1; start = 1'b0; base_addr = 6'h0; req_valid = 1'b0; req_last = 1'b0;
    imem_ready = 1'b1;
    clr_req();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst we", {31'h0, imem_we}, 32'h0);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst err", {31'h0, err}, 32'h0);
    chk("rst ready", {31'h0, req_ready}, 32'h0);
    chk("rst addr", {26'h0, imem_addr}, 32'h0);
    chk("rst wdata", imem_wdata, 32'h0);
    @(posedge clk); #1;

    // Single ADD R1,R2,#5 at 0x10
    log6.delete();
    start_session(6'h10);
    @(negedge clk);
    chk("A busy", {31'h0, busy}, 32'h1);
    chk("A addr load", {26'h0, imem_addr}, 32'h10);
    chk("A we idle", {31'h0, imem_we}, 32'h0);
    @(posedge clk); #1;
    set_dp(COND_AL, DP_ADD, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 5'd0, 2'b00, 12'h005);
    issue(1'b1);
    @(negedge clk);
    chk("A we", {31'h0, imem_we}, 32'h1);
    chk("A wr addr", {26'h0, imem_addr}, 32'h10);
    chk("A wr data", imem_wdata, 32'hE2821005);
    @(posedge clk); #1;
    wait_done("A");
    chk("A writes", log6.size(), 32'd1);

    // Mixed DP/MEM/BR program at 0x20, ending with a BR carrying L=1
    log6.delete();
    start_session(6'h20);
    set_dp(COND_AL, DP_SUB, 1'b1, 1'b0, 4'd4, 4'd3, 4'd5, 5'd2, 2'b00, 12'h0);
    issue(1'b0);
    set_dp(COND_AL, DP_SUB, 1'b0, 1'b0, 4'd4, 4'd3, 4'd5, 5'd31, 2'b10, 12'h0);
    issue(1'b0);
    set_mem(COND_AL, 1'b1, 1'b1, 4'd1, 4'd0, 12'h008);
    issue(1'b0);
    set_mem(COND_AL, 1'b0, 1'b0, 4'd1, 4'd0, 12'h004);
    issue(1'b0);
    set_dp(COND_AL, DP_AND, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 5'd0, 2'b00, 12'h0);
    issue(1'b0);
    set_dp(COND_AL, DP_ORR, 1'b0, 1'b1, 4'd7, 4'd6, 4'd0, 5'd0, 2'b00, 12'h0FF);
    issue(1'b0);
    set_dp(COND_AL, DP_CMP, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 5'd0, 2'b00, 12'h001);
    issue(1'b0);
    set_br(4'h0, 1'b0, 24'hFFFFFE);
    issue(1'b0);
    set_br(COND_AL, 1'b1, 24'hFFFFFE);
    issue(1'b1);
    wait_done("B");
    for (int k = 0; k < 8; k++) chk_log6(k, 6'h20 + 6'(k), exp_b[k]);
`ifdef INSTR_ENC_BL_EN
    chk("B writes", log6.size(), 32'd9);
    chk_log6(8, 6'h28, 32'hEBFFFFFE);
    chk("B err", {31'h0, err}, 32'h0);
`else
    chk("B writes", log6.size(), 32'd8);
    chk("B err", {31'h0, err}, 32'h1);
`endif

    // Stall: six requests with imem_ready low, FIFO fills after four
    log6.delete();
    imem_ready = 1'b0;
    start_session(6'h30);
    chk("S err cleared", {31'h0, err}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      set_dp(COND_AL, DP_ADD, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 5'd0, 2'b00, 12'(k));
      issue(1'b0);
    end
    set_dp(COND_AL, DP_ADD, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 5'd0, 2'b00, 12'd5);
    req_valid = 1'b1;
    @(negedge clk);
    chk("S ready low", {31'h0, req_ready}, 32'h0);
    chk("S we", {31'h0, imem_we}, 32'h1);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("S stall%0d addr", j), {26'h0, imem_addr}, 32'h30);
      chk($sformatf("S stall%0d data", j), imem_wdata, 32'hE2821001);
      @(negedge clk);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    issue(1'b0);
    set_dp(COND_AL, DP_ADD, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 5'd0, 2'b00, 12'd6);
    issue(1'b1);
    wait_done("S");
    chk("S writes", log6.size(), 32'd6);
    for (int k = 0; k < 6; k++) chk_log6(k, 6'h30 + 6'(k), 32'hE2821001 + 32'(k));

    // Address wrap on the 4-bit instance: E, F, 0
    log6.delete();
    log4.delete();
    start_session(6'h0E);
    for (int k = 7; k <= 9; k++) begin
      set_dp(COND_AL, DP_ADD, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 5'd0, 2'b00, 12'(k));
      issue(k == 9);
    end
    wait_done("W");
    chk("W writes4", log4.size(), 32'd3);
    chk_log4(0, 4'hE, 32'hE2821007);
    chk_log4(1, 4'hF, 32'hE2821008);
    chk_log4(2, 4'h0, 32'hE2821009);
    chk_log6(2, 6'h10, 32'hE2821009);

    // Illegal op carrying last: dropped, err set, session still completes
    log6.delete();
    start_session(6'h05);
    clr_req();
    req_op = 2'b11;
    issue(1'b1);
    @(negedge clk);
    chk("I we", {31'h0, imem_we}, 32'h0);
    chk("I err", {31'h0, err}, 32'h1);
    @(posedge clk); #1;
    wait_done("I");
    chk("I writes", log6.size(), 32'd0);
    chk("I err sticky", {31'h0, err}, 32'h1);

    // Reset during FLUSH with two words buffered
    log6.delete();
    imem_ready = 1'b0;
    start_session(6'h08);
    chk("R err cleared", {31'h0, err}, 32'h0);
    set_dp(COND_AL, DP_ADD, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 5'd0, 2'b00, 12'h00A);
    issue(1'b0);
    issue(1'b1);
    @(negedge clk);
    chk("R busy pre", {31'h0, busy}, 32'h1);
    chk("R we pre", {31'h0, imem_we}, 32'h1);
    c_before = done_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("R we", {31'h0, imem_we}, 32'h0);
    chk("R busy", {31'h0, busy}, 32'h0);
    chk("R done", {31'h0, done}, 32'h0);
    chk("R addr", {26'h0, imem_addr}, 32'h0);
    imem_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("R no writes", log6.size(), 32'd0);
    chk("R no done", done_cnt - c_before, 32'd0);
    chk("R still idle", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encodes structured instruction requests into 32-bit ARMv4 words (DP, LDR/STR immediate, B/BL). This is the inverse of the control-unit decode path.
- Buffers encoded words in a small FIFO and drains them into the instruction-memory write port at consecutive word addresses.
- Used by the boot/program loader and by testbenches to build programs for the single-cycle core.

Parameters:
- ADDR_W, 6, instruction-memory word-address width.
- FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a load session; sampled only in IDLE
- base_addr  in  ADDR_W  first word address of the session
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  2  00 DP, 01 MEM, 10 BR, 11 illegal
- req_cond  in  4  condition field
- req_cmd  in  4  DP opcode
- req_s  in  1  DP set-flags
- req_i  in  1  DP immediate select
- req_rn, req_rd, req_rm  in  4 each  register fields
- req_shamt  in  5  DP register shift amount
- req_sh  in  2  DP shift type
- req_imm12  in  12  DP rot/imm8 or MEM offset
- req_imm24  in  24  branch offset
- req_l  in  1  MEM load / BR link
- req_u  in  1  MEM add offset
- req_last  in  1  final request of the session
- imem_we  out  1  write strobe
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky illegal-request flag; cleared by start

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0; address counter 0.
- FSM:
  - IDLE → RUN on start; the address counter loads base_addr and err clears.
  - RUN → FLUSH when the accepted request has req_last=1.
  - FLUSH → DONE when the FIFO is empty and no write is pending.
  - DONE → IDLE unconditionally; done=1 only in DONE.
- req_ready = (state==RUN) && !fifo_full. A push while full is never allowed, even if a pop occurs in the same cycle.
- Encoding is combinational on the accepted request; the word is pushed into the FIFO the same cycle.
- DP word:
  - [31:28] cond, [27:26] 00, [25] I, [24:21] cmd, [20] S, [19:16] Rn, [15:12] Rd.
  - [11:0] = imm12 when I=1; otherwise {shamt, sh, 0, Rm}.
- MEM word: cond, 01, [25]=0, P=1, [23]=U, B=0, W=0, [20]=L, Rn, Rd, imm12.
- BR word: cond, 101, [24]=L, imm24.
- Illegal requests are accepted but dropped: no push, err←1. Illegal means op=11, or BR with L=1 when BL is disabled.
- An illegal request carrying req_last still moves the FSM to FLUSH.
- Write port:
  - imem_we=1 whenever the FIFO is non-empty; imem_wdata/addr come from the FIFO head and the address counter.
  - Pop and counter increment happen only on imem_we && imem_ready. Outputs stay stable while stalled.
- Latency: a word accepted in cycle N appears on imem_we in cycle N+1 at the earliest. Throughput is 1 word/cycle when imem_ready=1.
- The address counter wraps modulo 2^ADDR_W silently.
- start in RUN/FLUSH/DONE is ignored. Reset at any point aborts the session: FIFO flushed, no further writes, done not pulsed.

Optional Feature:
- Macro INSTR_ENC_BL_EN.
- Defined: BR with req_l=1 encodes bit 24=1 (BL).
- Undefined: BR with req_l=1 is illegal (dropped, err set); BR is always encoded with bit 24=0.

Decomposition:
- Package instr_enc_pkg holds:
  - op enum (OP_DP, OP_MEM, OP_BR, OP_ILL);
  - state enum;
  - COND_AL=4'hE;
  - DP opcode constants (ADD=4'b0100, SUB=4'b0010, AND, ORR, CMP);
  - field bit-position localparams.
- One sub-module, sync_fifo (parameterised width/depth, full/empty, synchronous reset). Encoding logic and FSM stay in the top.

Test Plan:
- ADD R1,R2,#5 (AL, I=1, S=0, imm12=005), base_addr=0x10, imem_ready=1 → one write: addr 0x10, data E2821005; then done pulse.
- SUBS R3,R4,R5 LSL #2 (I=0, S=1, shamt=2, sh=00) → E0543105. LDR R0,[R1,#8] → E5910008. STR R0,[R1,#-4] (U=0) → E5010004. All at consecutive addresses.
- BEQ imm24=FFFFFE → 0AFFFFFE. BR with L=1: with INSTR_ENC_BL_EN → EBFFFFFE; without it → no write, err=1.
- Hold imem_ready=0 and issue 6 back-to-back requests → req_ready drops after 4 accepts. Release imem_ready → all 6 words written in order, no loss or duplication, data/addr stable during the stall.
- ADDR_W=4, base_addr=0xE, 3 requests → addresses E, F, 0. op=11 with req_last → no write, err=1, FSM reaches DONE.
- Assert reset during FLUSH with 2 words buffered → next cycle imem_we=0, busy=0, FIFO empty, no done pulse.
